// File: rtl/snake_key_direction.sv
// Board KEY conditioning for the snake core: two-flop sync, per-key debounce,
// press-to-direction events with legality filtering, and an Avalon-MM event FIFO.
module snake_key_direction #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned RESET_HEADING   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    DEPTH     = 5'(FIFO_DEPTH);
  localparam logic [1:0]    HEAD_INIT = 2'(RESET_HEADING);

  logic [3:0]    sync1, sync2, pressed_raw, deb, deb_q, press;
  logic [CW-1:0] cnt [4];

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow, irq_en;
  logic [1:0]    heading;

  logic          has_cand, legal, empty, full;
  logic [1:0]    cand_dir;
  logic          pop, push, drop, flush, ctrl_wr, stat_wr;
  logic          unused_wd;

  assign pressed_raw = ~sync2;
  assign press       = deb & ~deb_q;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH);
  assign irq         = irq_en && !empty;
  assign unused_wd   = ^{avs_writedata[31:10], avs_writedata[8:5]};

  // Lowest-index simultaneous press wins; the rest are discarded.
  always_comb begin
    has_cand = 1'b0;
    cand_dir = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (press[i] && !has_cand) begin
        has_cand = 1'b1;
        cand_dir = 2'(i);
      end
    end
  end

  assign legal   = has_cand && (cand_dir != heading) && (cand_dir != (heading ^ 2'd2));
  assign ctrl_wr = avs_write && (avs_address == 2'd2);
  assign stat_wr = avs_write && (avs_address == 2'd1);
  assign flush   = ctrl_wr && avs_writedata[1];
  assign pop     = avs_read && (avs_address == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = legal && !flush && (!full || pop);
  assign drop    = legal && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (pressed_raw[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= cand_dir;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      heading  <= HEAD_INIT;
    end else begin
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + {4'b0, push} - {4'b0, pop};
        if (drop)
          overflow <= 1'b1;
        else if (stat_wr && avs_writedata[9])
          overflow <= 1'b0;
      end
      if (ctrl_wr) irq_en <= avs_writedata[0];
      if (push)
        heading <= cand_dir;
      else if (ctrl_wr && avs_writedata[4])
        heading <= avs_writedata[3:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= empty ? '0 : {1'b1, 29'd0, mem[rd_ptr]};
        2'd1:    avs_readdata <= {18'd0, heading, full, empty, overflow, count, deb};
        2'd2:    avs_readdata <= {31'd0, irq_en};
        default: avs_readdata <= '0;
      endcase
    end
  end

endmodule
